// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEASURE  = 2'd1,
      OVERFLOW = 2'd2
   } state_e;

   localparam int MCNT_W = 4;

   function automatic logic [63:0] cnt_max(input int w);
      cnt_max = (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/period_meter_rise_detect.sv
// Rising-edge detector for tick_i; with PERIOD_METER_SYNC_EN defined a
// two-flop synchronizer precedes the history register. All flops reset to 1.
module rise_detect (
   input  logic clock_i,
   input  logic reset_i,
   input  logic tick_i,
   output logic rise_o
);

   logic tick_s;
   logic tick_d_q;

`ifdef PERIOD_METER_SYNC_EN
   logic [1:0] sync_q;

   // Two-flop synchronizer; reset high so a high input at release is no edge
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], tick_i};
      end
   end

   assign tick_s = sync_q[1];
`else
   assign tick_s = tick_i;
`endif

   // Edge history; clear does not touch it so only true edges restart a measurement
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         tick_d_q <= 1'b1;
      end else begin
         tick_d_q <= tick_s;
      end
   end

   assign rise_o = tick_s & ~tick_d_q;

endmodule

// File: rtl/period_meter.sv
// Period meter: measures cycles between rising edges of tick_in and keeps
// last/min/max/overflow/count statistics. Optional macro: PERIOD_METER_SYNC_EN.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tick_in,
   input  logic              clear,
   output logic [WIDTH-1:0]  period,
   output logic              period_valid,
   output logic [WIDTH-1:0]  period_min,
   output logic [WIDTH-1:0]  period_max,
   output logic              overflow,
   output logic [MCNT_W-1:0] meas_count
);

   localparam logic [WIDTH-1:0] CntMax = WIDTH'(cnt_max(WIDTH));

   logic              rise_s;
   state_e            state_q, state_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  period_q, period_d;
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  min_q, min_d;
   logic [WIDTH-1:0]  max_q, max_d;
   logic              ovf_q, ovf_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;

   rise_detect u_rise_detect (
      .clock_i (clock),
      .reset_i (reset),
      .tick_i  (tick_in),
      .rise_o  (rise_s)
   );

   // Next-state, counter and statistics; clear beats a coincident rise
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      valid_d  = 1'b0;
      min_d    = min_q;
      max_d    = max_q;
      ovf_d    = ovf_q;
      mcnt_d   = mcnt_q;
      if (clear) begin
         state_d  = IDLE;
         cnt_d    = '0;
         period_d = '0;
         min_d    = '1;
         max_d    = '0;
         ovf_d    = 1'b0;
         mcnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_s) begin
                  cnt_d   = WIDTH'(1);
                  state_d = MEASURE;
               end else begin
                  state_d = IDLE;
               end
            end
            MEASURE: begin
               if (rise_s) begin
                  period_d = cnt_q;
                  valid_d  = 1'b1;
                  mcnt_d   = mcnt_q + MCNT_W'(1);
                  cnt_d    = WIDTH'(1);
                  if (cnt_q < min_q) begin
                     min_d = cnt_q;
                  end else begin
                     min_d = min_q;
                  end
                  if (cnt_q > max_q) begin
                     max_d = cnt_q;
                  end else begin
                     max_d = max_q;
                  end
               end else if (cnt_q == CntMax) begin
                  // Counter saturated: interval unmeasurable, wait for the next edge
                  ovf_d   = 1'b1;
                  state_d = OVERFLOW;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
            OVERFLOW: begin
               if (rise_s) begin
                  cnt_d   = WIDTH'(1);
                  state_d = MEASURE;
               end else begin
                  state_d = OVERFLOW;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and statistics registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         min_q    <= '1;
         max_q    <= '0;
         ovf_q    <= 1'b0;
         mcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         min_q    <= min_d;
         max_q    <= max_d;
         ovf_q    <= ovf_d;
         mcnt_q   <= mcnt_d;
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;
   assign period_min   = min_q;
   assign period_max   = max_q;
   assign overflow     = ovf_q;
   assign meas_count   = mcnt_q;

endmodule
